fmm_row_seq: RTL and testbench

Sequencer for the FMM matrix-multiply datapath: computes one 256-bit output row C = cin + Σₖ A[k]·B[k] by stepping the `matrix_ops` multiply-accumulate unit through its word-select opcodes 1..N, one per cycle. It holds the running sum in an internal register and fetches B rows through a simple address/valid port. It tolerates stalls on B delivery and reports completion with a one-cycle `done` pulse. It sits between the FMM instruction decode (`start`, operands) and the B-row register file.

---
 rtl/fmm_pkg.sv | 22 ++
 rtl/matrix_ops.sv | 34 +++
 rtl/fmm_row_seq.sv | 110 +++++++++++
 tb/tb_fmm_row_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fmm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fmm_pkg
// Description : Shared widths and state encoding for the FMM row sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fmm_pkg;

    localparam int FMM_WORD    = 32;
    localparam int FMM_ROW     = 256;
    localparam int FMM_MAX_LEN = 8;
    localparam int FMM_IDX_W   = 3;
    localparam int FMM_OP_W    = 4;

    typedef logic [1:0] fmm_state_t;

    localparam fmm_state_t c_st_idle = 2'd0;
    localparam fmm_state_t c_st_run  = 2'd1;
    localparam fmm_state_t c_st_done = 2'd2;

endpackage
`default_nettype wire

// File: rtl/matrix_ops.sv
`default_nettype none
// ============================================================================
// Module      : matrix_ops
// Description : MAC step: co = A[op-1] * b + cin (mod 2^256), b as one integer.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_ops
    import fmm_pkg::*;
(
    input  logic                mm_en,
    input  logic [FMM_OP_W-1:0] mm_op,
    input  logic [FMM_ROW-1:0]  a,
    input  logic [FMM_ROW-1:0]  b,
    input  logic [FMM_ROW-1:0]  cin,
    output logic [FMM_ROW-1:0]  co
);

    logic [FMM_WORD-1:0] w_word;
    logic [FMM_ROW-1:0]  w_prod;

    // Opcodes outside 1..FMM_MAX_LEN select a zero word, so co falls back to cin.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < FMM_MAX_LEN; i++) begin
            if (mm_op == FMM_OP_W'(i + 1)) begin
                w_word = a[i*FMM_WORD +: FMM_WORD];
            end
        end
        w_prod = FMM_ROW'(w_word) * b;
        co     = mm_en ? (w_prod + cin) : cin;
    end

endmodule
`default_nettype wire

// File: rtl/fmm_row_seq.sv
`default_nettype none
// ============================================================================
// Module      : fmm_row_seq
// Description : Steps matrix_ops through MM_LEN MAC ops to build one output row.
// Revision    : 1.0 - initial release
// ============================================================================
module fmm_row_seq
    import fmm_pkg::*;
#(
    parameter int MM_LEN = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 acc_clear,
    input  logic [FMM_ROW-1:0]   a_row,
    input  logic [FMM_ROW-1:0]   c_init,
    output logic [FMM_IDX_W-1:0] b_addr,
    input  logic [FMM_ROW-1:0]   b_data,
    input  logic                 b_valid,
    output logic                 busy,
    output logic                 done,
    output logic [FMM_ROW-1:0]   c_row
);

    localparam logic [FMM_IDX_W-1:0] c_last_k = FMM_IDX_W'(MM_LEN - 1);

    fmm_state_t           r_state;
    logic [FMM_IDX_W-1:0] r_k;
    logic [FMM_IDX_W-1:0] r_b_addr;
    logic [FMM_ROW-1:0]   r_acc;
    logic [FMM_ROW-1:0]   r_a;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_mm_en;
    logic [FMM_OP_W-1:0]  w_mm_op;
    logic [FMM_ROW-1:0]   w_co;

    assign w_mm_en = (r_state == c_st_run) && b_valid;
    assign w_mm_op = {1'b0, r_k} + FMM_OP_W'(1);

    matrix_ops u_matrix_ops (
        .mm_en (w_mm_en),
        .mm_op (w_mm_op),
        .a     (r_a),
        .b     (b_data),
        .cin   (r_acc),
        .co    (w_co)
    );

    // Outputs are registered alongside the state so nothing combinational reaches them from start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_k      <= '0;
            r_b_addr <= '0;
            r_acc    <= '0;
            r_a      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a      <= a_row;
                        r_acc    <= acc_clear ? '0 : c_init;
                        r_k      <= '0;
                        r_b_addr <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (b_valid) begin
                        r_acc <= w_co;
                        if (r_k == c_last_k) begin
                            r_b_addr <= '0;
                            r_done   <= 1'b1;
                            r_state  <= c_st_done;
                        end else begin
                            r_k      <= r_k + 1'b1;
                            r_b_addr <= r_k + 1'b1;
                        end
                    end
                end
                c_st_done: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_k     <= '0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_k      <= '0;
                    r_b_addr <= '0;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

    assign b_addr = r_b_addr;
    assign busy   = r_busy;
    assign done   = r_done;
    assign c_row  = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_fmm_row_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmm_row_seq
// Description : Directed self-checking bench for fmm_row_seq (MM_LEN 8 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmm_row_seq;

    localparam int LEN = 8;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, acc_clear, b_valid;
    logic [255:0] a_row, c_init, b_data;
    logic [2:0]   b_addr;
    logic         busy, done;
    logic [255:0] c_row;

    logic         start2, b_valid2;
    logic [255:0] b_data2;
    logic [2:0]   b_addr2;
    logic         busy2, done2;
    logic [255:0] c_row2;

    logic [255:0] brows [LEN];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    fmm_row_seq #(.MM_LEN(LEN)) dut (
        .clk(clk), .reset(reset), .start(start), .acc_clear(acc_clear),
        .a_row(a_row), .c_init(c_init), .b_addr(b_addr), .b_data(b_data),
        .b_valid(b_valid), .busy(busy), .done(done), .c_row(c_row)
    );

    fmm_row_seq #(.MM_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .start(start2), .acc_clear(acc_clear),
        .a_row(a_row), .c_init(c_init), .b_addr(b_addr2), .b_data(b_data2),
        .b_valid(b_valid2), .busy(busy2), .done(done2), .c_row(c_row2)
    );

    // B-row register file.
    always_comb b_data = brows[b_addr];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Row-level model: running sum of A[k]*B[k] with plain integer arithmetic.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_k = 0;
    logic [255:0] m_acc = '0;
    logic [255:0] m_a = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_k    <= 0;
            m_acc  <= '0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_a    <= a_row;
                m_acc  <= acc_clear ? 256'd0 : c_init;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (b_valid) begin
            m_acc <= m_acc + 256'(m_a[m_k*32 +: 32]) * brows[m_k];
            if (m_k == LEN - 1) m_done <= 1'b1;
            else                m_k    <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 256'(busy), 256'(m_busy));
            check("done", 256'(done), 256'(m_done));
            check("b_addr", 256'(b_addr), (m_busy && !m_done) ? 256'(m_k) : 256'd0);
            check("c_row", c_row, m_acc);
        end
    end

    task automatic run_row(input logic [255:0] a0, input logic [255:0] a_later,
                           input logic clr, input logic [255:0] ci,
                           input logic [63:0] stall, input logic [63:0] xstart,
                           input int rst_at, input int ncyc,
                           output int first_done, output int last_done);
        first_done = -1;
        last_done  = -1;
        for (int n = 0; n < ncyc; n++) begin
            start     = (n == 0) || xstart[n];
            reset     = (n == rst_at);
            b_valid   = !stall[n];
            a_row     = (n == 0) ? a0 : a_later;
            acc_clear = (n == 0) ? clr : 1'b1;
            c_init    = (n == 0) ? ci : {8{32'($urandom())}};
            @(negedge clk);
            if (done === 1'b1) begin
                if (first_done < 0) first_done = n;
                last_done = n;
            end
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        reset   = 1'b0;
        b_valid = 1'b1;
    endtask

    int fd, ld;
    logic [255:0] ones_a;
    logic [255:0] twos_a;
    logic [255:0] wrap_exp;

    initial begin
        ones_a   = {8{32'd1}};
        twos_a   = {8{32'd2}};
        wrap_exp = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_00000001;
        for (int k = 0; k < LEN; k++) brows[k] = 256'(k + 1);
        reset = 1'b1; start = 1'b0; start2 = 1'b0; acc_clear = 1'b1;
        a_row = '0; c_init = '0; b_valid = 1'b1; b_valid2 = 1'b1; b_data2 = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", 256'(busy), 256'd0);
        check("reset_done", 256'(done), 256'd0);
        check("reset_b_addr", 256'(b_addr), 256'd0);
        check("reset_c_row", c_row, 256'd0);
        check("reset_c_row2", c_row2, 256'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic row: sum of 1..8.
        run_row(ones_a, ones_a, 1'b1, '0, 64'h0, 64'h0, -1, 11, fd, ld);
        check("basic_done_cycle", 256'(fd), 256'd9);
        check("basic_c_row", c_row, 256'd36);

        // Stalls at k=2 (3 cycles) and k=7 (1 cycle).
        run_row(ones_a, ones_a, 1'b1, '0, 64'h838, 64'h0, -1, 15, fd, ld);
        check("stall_done_cycle", 256'(fd), 256'd13);
        check("stall_c_row", c_row, 256'd36);

        // Starts in RUN and DONE are dropped; the one in the following IDLE cycle is taken.
        run_row(ones_a, twos_a, 1'b1, '0, 64'h0, 64'h608, -1, 21, fd, ld);
        check("busy_start_first_done", 256'(fd), 256'd9);
        check("busy_start_second_done", 256'(ld), 256'd19);
        check("busy_start_c_row", c_row, 256'd72);

        // Reset at k=4 together with start.
        run_row(ones_a, ones_a, 1'b1, '0, 64'h0, 64'h20, 5, 6, fd, ld);
        check("midrst_no_done", 256'(fd), 256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff);
        @(negedge clk);
        check("midrst_busy", 256'(busy), 256'd0);
        check("midrst_c_row", c_row, 256'd0);
        @(posedge clk);
        #1;

        // Accumulate onto c_init.
        run_row(ones_a, ones_a, 1'b0, 256'd100, 64'h0, 64'h0, -1, 11, fd, ld);
        check("accum_done_cycle", 256'(fd), 256'd9);
        check("accum_c_row", c_row, 256'd136);

        // MM_LEN=1 with cross-lane carries.
        a_row     = {192'd0, 32'd5, 32'hFFFFFFFF};
        acc_clear = 1'b1;
        b_data2   = {1'b0, {255{1'b1}}};
        start2    = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        start2 = 1'b0;
        @(negedge clk);
        check("len1_c1_busy", 256'(busy2), 256'd1);
        check("len1_c1_done", 256'(done2), 256'd0);
        check("len1_c1_b_addr", 256'(b_addr2), 256'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("len1_c2_done", 256'(done2), 256'd1);
        check("len1_c_row", c_row2, wrap_exp);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("len1_c3_busy", 256'(busy2), 256'd0);
        check("len1_c3_done", 256'(done2), 256'd0);
        check("len1_hold_c_row", c_row2, wrap_exp);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
